hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV32I pipeline. Generates stall/flush for every pipeline register (F/D/E/M/W) and forwarding selects for the execute stage. Owns a small FSM for post-reset pipeline scrub, because pipeline registers have no reset, and for data-memory wait states. Also keeps saturating stall and flush performance counters.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/hazard_ctrl_fwd_unit.sv | 39 +++
 rtl/hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the RV32I pipeline control blocks.
//   REG_ADDR_W  : width of a register-file address
//   hz_state_t  : hazard controller sequencing states (INIT, RUN, MEM_WAIT)
//   fwd_sel_t   : execute-stage operand forwarding select
//                 FWD_RF = register file, FWD_W = W result, FWD_M = M ALU result
//   reg_hit()   : true when a writing stage targets a non-x0 register that
//                 matches a source register
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_t;

   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_RF = 2'b00;
   localparam fwd_sel_t FWD_W  = 2'b01;
   localparam fwd_sel_t FWD_M  = 2'b10;

   // x0 is hard-wired to zero, so a write to it never produces a usable result.
   function automatic logic reg_hit(
      input logic [REG_ADDR_W-1:0] rd,
      input logic                  we,
      input logic [REG_ADDR_W-1:0] rs
   );
      return we && (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Combinational forwarding select for one execute-stage source operand.
// Ports:
//   i_rs          : source register read by the instruction in E
//   i_rd_m        : destination register of the instruction in M
//   i_regwrite_m  : M instruction writes the register file
//   i_rd_w        : destination register of the instruction in W
//   i_regwrite_w  : W instruction writes the register file
//   o_sel         : FWD_M / FWD_W / FWD_RF select
// -----------------------------------------------------------------------------
module fwd_unit
   import riscv_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] i_rs,
   input  logic [REG_ADDR_W-1:0] i_rd_m,
   input  logic                  i_regwrite_m,
   input  logic [REG_ADDR_W-1:0] i_rd_w,
   input  logic                  i_regwrite_w,
   output fwd_sel_t              o_sel
);

   logic w_hit_m;
   logic w_hit_w;

   assign w_hit_m = reg_hit(i_rd_m, i_regwrite_m, i_rs);
   assign w_hit_w = reg_hit(i_rd_w, i_regwrite_w, i_rs);

   // M holds the younger result, so it wins when both stages match.
   always_comb begin
      o_sel = FWD_RF;
      if (w_hit_m) begin
         o_sel = FWD_M;
      end else if (w_hit_w) begin
         o_sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Pipeline registers have no reset, so after reset the controller flushes every
// stage for INIT_CYCLES clocks before normal operation. It also resolves
// load-use stalls, taken-branch flushes, data-memory wait states and operand
// forwarding, and keeps saturating stall/flush performance counters.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   Rs1_D, Rs2_D                  : decode-stage source registers
//   Rs1_E, Rs2_E, Rd_E, Load_E    : execute-stage fields, load flag
//   PCSrc_E                       : taken branch/jump resolved in E
//   Rd_M, RegWrite_M              : M destination and write enable
//   Rd_W, RegWrite_W              : W destination and write enable
//   dmem_req_M, dmem_ready        : M-stage memory request / completion
//   Stall_F/D/E/M                 : hold the stage register
//   Flush_D/E/M/W                 : insert a bubble
//   ForwardA_E, ForwardB_E        : operand forwarding selects
//   mem_timeout                   : sticky, memory wait reached MAX_WAIT
//   stall_cycles, flush_events    : saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int INIT_CYCLES = 4,
   parameter int MAX_WAIT    = 64,
   parameter int CNT_WIDTH   = 32
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] Rs1_D,
   input  logic [REG_ADDR_W-1:0] Rs2_D,
   input  logic [REG_ADDR_W-1:0] Rs1_E,
   input  logic [REG_ADDR_W-1:0] Rs2_E,
   input  logic [REG_ADDR_W-1:0] Rd_E,
   input  logic                  Load_E,
   input  logic                  PCSrc_E,
   input  logic [REG_ADDR_W-1:0] Rd_M,
   input  logic [REG_ADDR_W-1:0] Rd_W,
   input  logic                  RegWrite_M,
   input  logic                  RegWrite_W,
   input  logic                  dmem_req_M,
   input  logic                  dmem_ready,
   output logic                  Stall_F,
   output logic                  Stall_D,
   output logic                  Stall_E,
   output logic                  Stall_M,
   output logic                  Flush_D,
   output logic                  Flush_E,
   output logic                  Flush_M,
   output logic                  Flush_W,
   output logic [1:0]            ForwardA_E,
   output logic [1:0]            ForwardB_E,
   output logic                  mem_timeout,
   output logic [CNT_WIDTH-1:0]  stall_cycles,
   output logic [CNT_WIDTH-1:0]  flush_events
);

   localparam int INIT_W = $clog2(INIT_CYCLES + 1);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   hz_state_t              r_state;
   hz_state_t              r_state_next;
   logic [INIT_W-1:0]      r_init_cnt;
   logic [WAIT_W-1:0]      r_wait_cnt;
   logic                   r_mem_timeout;
   logic [CNT_WIDTH-1:0]   r_stall_cycles;
   logic [CNT_WIDTH-1:0]   r_flush_events;

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   logic       w_lw_stall;
   logic       w_mem_wait;
   logic       w_release;
   fwd_sel_t   w_fwd_a;
   fwd_sel_t   w_fwd_b;

   assign w_lw_stall = Load_E && (Rd_E != '0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
   assign w_mem_wait = dmem_req_M && !dmem_ready;
   // A ready strobe only counts while a request is actually outstanding.
   assign w_release  = dmem_req_M && dmem_ready;

   fwd_unit u_fwd_a (
      .i_rs         (Rs1_E),
      .i_rd_m       (Rd_M),
      .i_regwrite_m (RegWrite_M),
      .i_rd_w       (Rd_W),
      .i_regwrite_w (RegWrite_W),
      .o_sel        (w_fwd_a)
   );

   fwd_unit u_fwd_b (
      .i_rs         (Rs2_E),
      .i_rd_m       (Rd_M),
      .i_regwrite_m (RegWrite_M),
      .i_rd_w       (Rd_W),
      .i_regwrite_w (RegWrite_W),
      .o_sel        (w_fwd_b)
   );

   // ---------------------------------------------------------------------------
   // Next state and stall/flush combination
   // ---------------------------------------------------------------------------
   logic       w_stall_f;
   logic       w_stall_d;
   logic       w_stall_e;
   logic       w_stall_m;
   logic       w_flush_d;
   logic       w_flush_e;
   logic       w_flush_m;
   logic       w_flush_w;
   logic       w_wait_active;
   logic       w_run_rules;
   logic       w_flush_applied;
   logic       w_in_init;

   always_comb begin
      r_state_next    = r_state;
      w_stall_f       = 1'b0;
      w_stall_d       = 1'b0;
      w_stall_e       = 1'b0;
      w_stall_m       = 1'b0;
      w_flush_d       = 1'b0;
      w_flush_e       = 1'b0;
      w_flush_m       = 1'b0;
      w_flush_w       = 1'b0;
      w_wait_active   = 1'b0;
      w_run_rules     = 1'b0;
      w_flush_applied = 1'b0;
      w_in_init       = 1'b0;

      case (r_state)
         INIT: begin
            // Only the state and init counter decide anything here, so
            // undriven pipeline inputs cannot leak into the outputs.
            w_in_init = 1'b1;
            w_stall_f = 1'b1;
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_flush_m = 1'b1;
            w_flush_w = 1'b1;
            if (r_init_cnt == INIT_LAST) begin
               r_state_next = RUN;
            end
         end
         RUN: begin
            // The wait stall must act in the very cycle the miss is seen.
            if (w_mem_wait) begin
               w_wait_active = 1'b1;
               r_state_next  = MEM_WAIT;
            end else begin
               w_run_rules = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (w_release) begin
               w_run_rules  = 1'b1;
               r_state_next = RUN;
            end else begin
               w_wait_active = 1'b1;
            end
         end
         default: begin
            r_state_next = INIT;
         end
      endcase

      // Whole front of the pipe freezes; W drains as a bubble each cycle.
      if (w_wait_active) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_stall_e = 1'b1;
         w_stall_m = 1'b1;
         w_flush_w = 1'b1;
      end

      // A taken branch discards the D instruction, so any load-use stall on
      // it is moot and fetch must move on to the branch target.
      if (w_run_rules) begin
         if (PCSrc_E) begin
            w_flush_d       = 1'b1;
            w_flush_e       = 1'b1;
            w_flush_applied = 1'b1;
         end else if (w_lw_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= INIT;
         r_init_cnt     <= '0;
         r_wait_cnt     <= '0;
         r_mem_timeout  <= 1'b0;
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         r_state <= r_state_next;

         if (w_in_init && (r_init_cnt != INIT_LAST)) begin
            r_init_cnt <= r_init_cnt + 1'b1;
         end

         // The counter holds at MAX_WAIT so it cannot wrap during long stalls.
         if (w_wait_active) begin
            if (r_wait_cnt != WAIT_MAX) begin
               r_wait_cnt <= r_wait_cnt + 1'b1;
               if (r_wait_cnt == WAIT_LAST) begin
                  r_mem_timeout <= 1'b1;
               end
            end
         end else begin
            r_wait_cnt <= '0;
         end

         if (!w_in_init && w_stall_f && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
         end

         if (w_flush_applied && (r_flush_events != '1)) begin
            r_flush_events <= r_flush_events + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign Stall_F      = w_stall_f;
   assign Stall_D      = w_stall_d;
   assign Stall_E      = w_stall_e;
   assign Stall_M      = w_stall_m;
   assign Flush_D      = w_flush_d;
   assign Flush_E      = w_flush_e;
   assign Flush_M      = w_flush_m;
   assign Flush_W      = w_flush_w;
   assign ForwardA_E   = w_in_init ? FWD_RF : w_fwd_a;
   assign ForwardB_E   = w_in_init ? FWD_RF : w_fwd_b;
   assign mem_timeout  = r_mem_timeout;
   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. A second instance with MAX_WAIT = 2 and
// 2-bit counters shares the stimulus to reach the timeout and saturation
// corners quickly.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
   logic       Load_E, PCSrc_E, RegWrite_M, RegWrite_W, dmem_req_M, dmem_ready;

   logic        Stall_F, Stall_D, Stall_E, Stall_M;
   logic        Flush_D, Flush_E, Flush_M, Flush_W;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic        mem_timeout;
   logic [31:0] stall_cycles, flush_events;

   logic        s2_stall_f, s2_stall_d, s2_stall_e, s2_stall_m;
   logic        s2_flush_d, s2_flush_e, s2_flush_m, s2_flush_w;
   logic [1:0]  s2_fwd_a, s2_fwd_b;
   logic        s2_timeout;
   logic [1:0]  s2_stall_cycles, s2_flush_events;

   int n_checks = 0;
   int n_errors = 0;

   hazard_ctrl #(.INIT_CYCLES(4), .MAX_WAIT(64), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
      .Load_E(Load_E), .PCSrc_E(PCSrc_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
      .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
      .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
      .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M), .Flush_W(Flush_W),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   hazard_ctrl #(.INIT_CYCLES(4), .MAX_WAIT(2), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
      .Load_E(Load_E), .PCSrc_E(PCSrc_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
      .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
      .Stall_F(s2_stall_f), .Stall_D(s2_stall_d), .Stall_E(s2_stall_e), .Stall_M(s2_stall_m),
      .Flush_D(s2_flush_d), .Flush_E(s2_flush_e), .Flush_M(s2_flush_m), .Flush_W(s2_flush_w),
      .ForwardA_E(s2_fwd_a), .ForwardB_E(s2_fwd_b),
      .mem_timeout(s2_timeout), .stall_cycles(s2_stall_cycles), .flush_events(s2_flush_events)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic idle();
      Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
      Load_E = 0; PCSrc_E = 0; RegWrite_M = 0; RegWrite_W = 0;
      dmem_req_M = 0; dmem_ready = 0;
   endtask

   task automatic check_init(input string tag);
      chk({tag, ".stall_f"}, {31'd0, Stall_F}, 32'd1);
      chk({tag, ".stall_dem"}, {29'd0, Stall_D, Stall_E, Stall_M}, 32'd0);
      chk({tag, ".flush_demw"}, {28'd0, Flush_D, Flush_E, Flush_M, Flush_W}, 32'hF);
      chk({tag, ".fwd"}, {28'd0, ForwardA_E, ForwardB_E}, 32'd0);
   endtask

   // Apply new inputs just after the active edge; checks follow 3 ns later.
   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic release_and_init(input string tag);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      #1;
      check_init($sformatf("%s_init0", tag));
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         check_init($sformatf("%s_init%0d", tag, k));
      end
      @(negedge clk);
      chk({tag, "_run.stall_f"}, {31'd0, Stall_F}, 32'd0);
      chk({tag, "_run.flush"}, {28'd0, Flush_D, Flush_E, Flush_M, Flush_W}, 32'd0);
      chk({tag, "_run.stall_cnt"}, stall_cycles, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      // Matching forwarding fields during reset must still give 00.
      Rs1_E = 5; Rs2_E = 5; Rd_M = 5; RegWrite_M = 1;
      #2;
      check_init("rst");
      chk("rst.stall_cnt", stall_cycles, 32'd0);
      chk("rst.flush_cnt", flush_events, 32'd0);
      chk("rst.timeout", {31'd0, mem_timeout}, 32'd0);

      release_and_init("boot");

      // Forwarding priority and x0 suppression
      settle();
      Rs1_E = 5; Rs2_E = 5; Rd_M = 5; RegWrite_M = 1; Rd_W = 5; RegWrite_W = 1;
      #3;
      chk("fwdA.m", {30'd0, ForwardA_E}, 32'd2);
      chk("fwdB.m", {30'd0, ForwardB_E}, 32'd2);
      RegWrite_M = 0;
      #1;
      chk("fwdA.w", {30'd0, ForwardA_E}, 32'd1);
      chk("fwdB.w", {30'd0, ForwardB_E}, 32'd1);
      RegWrite_M = 1; Rd_M = 0; Rs1_E = 0;
      #1;
      chk("fwdA.x0", {30'd0, ForwardA_E}, 32'd0);
      chk("fwdB.w2", {30'd0, ForwardB_E}, 32'd1);
      chk("fwd.no_stall", {31'd0, Stall_F}, 32'd0);

      // Load-use stall
      settle();
      idle();
      Load_E = 1; Rd_E = 7; Rs2_D = 7;
      #3;
      chk("lu.stall_fd", {30'd0, Stall_F, Stall_D}, 32'd3);
      chk("lu.flush_e", {31'd0, Flush_E}, 32'd1);
      chk("lu.flush_d", {31'd0, Flush_D}, 32'd0);
      chk("lu.stall_em", {30'd0, Stall_E, Stall_M}, 32'd0);

      settle();
      idle();
      #3;
      chk("lu.after", {31'd0, Stall_F}, 32'd0);
      chk("lu.stall_cnt", stall_cycles, 32'd1);
      chk("lu.stall_cnt2", {30'd0, s2_stall_cycles}, 32'd1);
      Load_E = 1; Rd_E = 0; Rs1_D = 0;
      #1;
      chk("lu.x0", {31'd0, Stall_F}, 32'd0);

      // Branch beats load-use
      settle();
      idle();
      Load_E = 1; Rd_E = 7; Rs2_D = 7; PCSrc_E = 1;
      #3;
      chk("br.flush_de", {30'd0, Flush_D, Flush_E}, 32'd3);
      chk("br.stall_fd", {30'd0, Stall_F, Stall_D}, 32'd0);

      settle();
      idle();
      #3;
      chk("br.flush_cnt", flush_events, 32'd1);
      chk("br.stall_cnt", stall_cycles, 32'd1);

      // Three memory wait cycles with a deferred branch
      for (int i = 0; i < 3; i++) begin
         settle();
         idle();
         dmem_req_M = 1; PCSrc_E = 1;
         #3;
         chk($sformatf("mw%0d.stall", i), {28'd0, Stall_F, Stall_D, Stall_E, Stall_M}, 32'hF);
         chk($sformatf("mw%0d.flush_w", i), {31'd0, Flush_W}, 32'd1);
         chk($sformatf("mw%0d.flush_de", i), {30'd0, Flush_D, Flush_E}, 32'd0);
         chk($sformatf("mw%0d.timeout", i), {31'd0, mem_timeout}, 32'd0);
         chk($sformatf("mw%0d.timeout2", i), {31'd0, s2_timeout}, (i == 2) ? 32'd1 : 32'd0);
         chk($sformatf("mw%0d.stall_cnt", i), stall_cycles, 32'd1 + 32'(i));
         chk($sformatf("mw%0d.stall_cnt2", i), {30'd0, s2_stall_cycles}, 32'd1 + 32'(i));
      end

      // Release cycle: normal rules, branch now applied
      settle();
      idle();
      dmem_req_M = 1; dmem_ready = 1; PCSrc_E = 1;
      #3;
      chk("rel.stall", {28'd0, Stall_F, Stall_D, Stall_E, Stall_M}, 32'd0);
      chk("rel.flush_w", {31'd0, Flush_W}, 32'd0);
      chk("rel.flush_de", {30'd0, Flush_D, Flush_E}, 32'd3);

      settle();
      idle();
      dmem_ready = 1;
      #3;
      chk("post.ready_only", {31'd0, Stall_F}, 32'd0);
      chk("post.stall_cnt", stall_cycles, 32'd4);
      chk("post.stall_sat", {30'd0, s2_stall_cycles}, 32'd3);
      chk("post.flush_cnt", flush_events, 32'd2);
      chk("post.timeout2", {31'd0, s2_timeout}, 32'd1);
      chk("post.timeout", {31'd0, mem_timeout}, 32'd0);

      // Reset in the middle of a memory wait
      settle();
      idle();
      dmem_req_M = 1;
      #3;
      chk("mw2.stall_m", {31'd0, Stall_M}, 32'd1);
      settle();
      #2;
      rst_n = 1'b0;
      #1;
      check_init("arst");
      chk("arst.stall_cnt", stall_cycles, 32'd0);
      chk("arst.flush_cnt", flush_events, 32'd0);
      chk("arst.timeout2", {31'd0, s2_timeout}, 32'd0);
      chk("arst.stall_cnt2", {30'd0, s2_stall_cycles}, 32'd0);

      release_and_init("reboot");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
